// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I-subset control unit:
// FSM states, opcode constants, datapath select codes and instruction classes.
package rv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_EXEC_CMP,
    S_EXEC_TGT,
    S_MEM,
    S_WB,
    S_TRAP
  } state_t;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LW = 7'b0000011;
  localparam logic [6:0] OP_SW = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;

  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  localparam logic [1:0] ALU_ADD   = 2'd0;
  localparam logic [1:0] ALU_SUB   = 2'd1;
  localparam logic [1:0] ALU_FUNCT = 2'd2;

  localparam logic [1:0] SRCB_RS2  = 2'd0;
  localparam logic [1:0] SRCB_IMM  = 2'd1;
  localparam logic [1:0] SRCB_FOUR = 2'd2;

  localparam logic [1:0] IMM_I    = 2'd0;
  localparam logic [1:0] IMM_S    = 2'd1;
  localparam logic [1:0] IMM_B    = 2'd2;
  localparam logic [1:0] IMM_NONE = 2'd3;

  localparam logic [1:0] CAUSE_NONE    = 2'd0;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'd2;

  typedef enum logic [2:0] {
    CLS_R,
    CLS_I,
    CLS_LW,
    CLS_SW,
    CLS_BR,
    CLS_ILL
  } iclass_t;

endpackage

// File: rtl/opcode_class.sv
// Combinational instruction classifier: opcode/funct3 to instruction class
// plus a legal flag; only BEQ and BNE are accepted among branches.
module opcode_class
  import rv_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  output logic [2:0] iclass,
  output logic       legal
);

  always_comb begin
    iclass = CLS_ILL;
    legal  = 1'b1;
    unique case (opcode)
      OP_R:  iclass = CLS_R;
      OP_I:  iclass = CLS_I;
      OP_LW: iclass = CLS_LW;
      OP_SW: iclass = CLS_SW;
      OP_BR: begin
        if (funct3 == F3_BEQ || funct3 == F3_BNE) begin
          iclass = CLS_BR;
        end else begin
          legal = 1'b0;
        end
      end
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM: sequences fetch/decode/execute/memory/writeback on a
// shared datapath, with a ready-handshake memory port, bus timeout and traps.
module multicycle_ctrl
  import rv_ctrl_pkg::*;
#(
  parameter int TIMEOUT_W = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        addr_sel,
  output logic        ir_we,
  output logic        mdr_we,
  output logic        pc_we,
  output logic        pc_src,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  alu_op,
  output logic [1:0]  imm_type,
  output logic        reg_we,
  output logic        wb_sel,
  output logic        trap,
  output logic [1:0]  trap_cause
);

  // The wait that would bring the counter to 2^W-1 is the one that times out.
  localparam logic [TIMEOUT_W-1:0] LAST_WAIT = TIMEOUT_W'((1 << TIMEOUT_W) - 2);

  state_t               state, next_state;
  logic [TIMEOUT_W-1:0] wait_cnt;
  logic                 zero_q;
  logic [2:0]           cls_raw;
  iclass_t              cls;
  logic                 legal;
  logic                 req_state;
  logic                 waiting;
  logic                 timeout;
  logic                 unused_instr_bits;

  opcode_class u_class (
    .opcode (instr[6:0]),
    .funct3 (instr[14:12]),
    .iclass (cls_raw),
    .legal  (legal)
  );

  assign cls               = iclass_t'(cls_raw);
  assign unused_instr_bits = ^{instr[31:15], instr[11:7]};

  assign req_state = (state == S_FETCH) || (state == S_MEM);
  assign waiting   = req_state & ~mem_ready;
  assign timeout   = waiting & (wait_cnt == LAST_WAIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      wait_cnt   <= '0;
      zero_q     <= 1'b0;
      trap_cause <= CAUSE_NONE;
    end else begin
      state    <= next_state;
      wait_cnt <= (waiting && next_state == state) ? wait_cnt + 1'b1 : '0;
      if (state == S_EXEC_CMP) begin
        zero_q <= zero;
      end
      if (state == S_DECODE && !legal) begin
        trap_cause <= CAUSE_ILLEGAL;
      end else if (timeout) begin
        trap_cause <= CAUSE_TIMEOUT;
      end
    end
  end

  always_comb begin
    next_state = state;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    addr_sel   = 1'b0;
    ir_we      = 1'b0;
    mdr_we     = 1'b0;
    pc_we      = 1'b0;
    pc_src     = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_RS2;
    alu_op     = ALU_ADD;
    imm_type   = IMM_I;
    reg_we     = 1'b0;
    wb_sel     = 1'b0;
    trap       = 1'b0;

    unique case (state)
      S_IDLE: next_state = S_FETCH;

      S_FETCH: begin
        mem_req = 1'b1;
        ir_we   = mem_ready;
        pc_we   = mem_ready;
        if (mem_ready) begin
          next_state = S_DECODE;
        end else if (timeout) begin
          next_state = S_TRAP;
        end
      end

      S_DECODE: begin
        if (!legal) begin
          next_state = S_TRAP;
        end else if (cls == CLS_BR) begin
          next_state = S_EXEC_CMP;
        end else begin
          next_state = S_EXEC;
        end
      end

      S_EXEC: begin
        next_state = S_FETCH;
        case (cls)
          CLS_R: begin
            alu_op     = ALU_FUNCT;
            imm_type   = IMM_NONE;
            next_state = S_WB;
          end
          CLS_I: begin
            alu_src_b  = SRCB_IMM;
            alu_op     = ALU_FUNCT;
            next_state = S_WB;
          end
          CLS_LW: begin
            alu_src_b  = SRCB_IMM;
            next_state = S_MEM;
          end
          CLS_SW: begin
            alu_src_b  = SRCB_IMM;
            imm_type   = IMM_S;
            next_state = S_MEM;
          end
          default: next_state = S_FETCH;
        endcase
      end

      // rs1 - rs2; the zero flag is captured at the end of this cycle
      S_EXEC_CMP: begin
        alu_op     = ALU_SUB;
        imm_type   = IMM_NONE;
        next_state = S_EXEC_TGT;
      end

      S_EXEC_TGT: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_IMM;
        imm_type   = IMM_B;
        pc_we      = instr[12] ? ~zero_q : zero_q;
        pc_src     = instr[12] ? ~zero_q : zero_q;
        next_state = S_FETCH;
      end

      S_MEM: begin
        mem_req  = 1'b1;
        addr_sel = 1'b1;
        mem_we   = (cls == CLS_SW);
        if (mem_ready) begin
          if (cls == CLS_LW) begin
            mdr_we     = 1'b1;
            next_state = S_WB;
          end else begin
            next_state = S_FETCH;
          end
        end else if (timeout) begin
          next_state = S_TRAP;
        end
      end

      S_WB: begin
        reg_we     = 1'b1;
        wb_sel     = (cls == CLS_LW);
        next_state = S_FETCH;
      end

      S_TRAP: trap = 1'b1;

      default: next_state = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed self-checking bench for multicycle_ctrl: per-cycle expected output
// vectors for each instruction class, traps, timeout and asynchronous reset.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] instr = 32'h0;
  logic        zero = 1'b0;
  logic        mem_ready = 1'b0;
  logic        mem_req, mem_we, addr_sel, ir_we, mdr_we, pc_we, pc_src, alu_src_a;
  logic [1:0]  alu_src_b, alu_op, imm_type;
  logic        reg_we, wb_sel, trap;
  logic [1:0]  trap_cause;
  logic [18:0] outs;

  int checks = 0;
  int errors = 0;

  multicycle_ctrl #(.TIMEOUT_W(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .instr      (instr),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .addr_sel   (addr_sel),
    .ir_we      (ir_we),
    .mdr_we     (mdr_we),
    .pc_we      (pc_we),
    .pc_src     (pc_src),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .imm_type   (imm_type),
    .reg_we     (reg_we),
    .wb_sel     (wb_sel),
    .trap       (trap),
    .trap_cause (trap_cause)
  );

  always #5 clk = ~clk;

  assign outs = {mem_req, mem_we, addr_sel, ir_we, mdr_we, pc_we, pc_src, alu_src_a,
                 alu_src_b, alu_op, imm_type, reg_we, wb_sel, trap, trap_cause};

  function automatic logic [18:0] ev(input logic req, input logic we, input logic asel,
                                     input logic irwe, input logic mdrwe, input logic pcwe,
                                     input logic pcsrc, input logic srca, input logic [1:0] srcb,
                                     input logic [1:0] op, input logic [1:0] imm,
                                     input logic regwe, input logic wbsel, input logic trp,
                                     input logic [1:0] cause);
    return {req, we, asel, irwe, mdrwe, pcwe, pcsrc, srca, srcb, op, imm, regwe, wbsel, trp, cause};
  endfunction

  localparam logic [18:0] E_ZERO   = ev(0,0,0,0,0,0,0,0,2'd0,2'd0,2'd0,0,0,0,2'd0);
  localparam logic [18:0] E_FWAIT  = ev(1,0,0,0,0,0,0,0,2'd0,2'd0,2'd0,0,0,0,2'd0);
  localparam logic [18:0] E_FOK    = ev(1,0,0,1,0,1,0,0,2'd0,2'd0,2'd0,0,0,0,2'd0);
  localparam logic [18:0] E_EXR    = ev(0,0,0,0,0,0,0,0,2'd0,2'd2,2'd3,0,0,0,2'd0);
  localparam logic [18:0] E_EXLW   = ev(0,0,0,0,0,0,0,0,2'd1,2'd0,2'd0,0,0,0,2'd0);
  localparam logic [18:0] E_EXSW   = ev(0,0,0,0,0,0,0,0,2'd1,2'd0,2'd1,0,0,0,2'd0);
  localparam logic [18:0] E_CMP    = ev(0,0,0,0,0,0,0,0,2'd0,2'd1,2'd3,0,0,0,2'd0);
  localparam logic [18:0] E_TGT_T  = ev(0,0,0,0,0,1,1,1,2'd1,2'd0,2'd2,0,0,0,2'd0);
  localparam logic [18:0] E_TGT_N  = ev(0,0,0,0,0,0,0,1,2'd1,2'd0,2'd2,0,0,0,2'd0);
  localparam logic [18:0] E_MEMW   = ev(1,0,1,0,0,0,0,0,2'd0,2'd0,2'd0,0,0,0,2'd0);
  localparam logic [18:0] E_MEMLW  = ev(1,0,1,0,1,0,0,0,2'd0,2'd0,2'd0,0,0,0,2'd0);
  localparam logic [18:0] E_MEMSW  = ev(1,1,1,0,0,0,0,0,2'd0,2'd0,2'd0,0,0,0,2'd0);
  localparam logic [18:0] E_WB     = ev(0,0,0,0,0,0,0,0,2'd0,2'd0,2'd0,1,0,0,2'd0);
  localparam logic [18:0] E_WBLW   = ev(0,0,0,0,0,0,0,0,2'd0,2'd0,2'd0,1,1,0,2'd0);
  localparam logic [18:0] E_TRAP1  = ev(0,0,0,0,0,0,0,0,2'd0,2'd0,2'd0,0,0,1,2'd1);
  localparam logic [18:0] E_TRAP2  = ev(0,0,0,0,0,0,0,0,2'd0,2'd0,2'd0,0,0,1,2'd2);

  // Leaves the bench on the negedge where rst_n is released (DUT in IDLE).
  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    mem_ready = 1'b0;
    zero = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    instr = 32'h002081B3;
    mem_ready = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (outs !== E_ZERO) begin
      errors++;
      $display("FAIL reset outputs: got %h expected %h", outs, E_ZERO);
    end
  endtask

  task automatic test_add();
    logic        rdy [6] = '{0, 1, 0, 0, 0, 0};
    logic [18:0] exp [6] = '{E_ZERO, E_FOK, E_ZERO, E_EXR, E_WB, E_FWAIT};
    instr = 32'h002081B3;
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clk);
      mem_ready = rdy[i];
      #1;
      checks++;
      if (outs !== exp[i]) begin
        errors++;
        $display("FAIL add cycle %0d: got %h expected %h", i, outs, exp[i]);
      end
    end
  endtask

  task automatic test_lw();
    logic        rdy [10] = '{0, 1, 0, 0, 0, 0, 0, 1, 0, 0};
    logic [18:0] exp [10] = '{E_ZERO, E_FOK, E_ZERO, E_EXLW, E_MEMW, E_MEMW, E_MEMW,
                              E_MEMLW, E_WBLW, E_FWAIT};
    instr = 32'h0000A183;
    apply_reset();
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge clk);
      mem_ready = rdy[i];
      #1;
      checks++;
      if (outs !== exp[i]) begin
        errors++;
        $display("FAIL lw cycle %0d: got %h expected %h", i, outs, exp[i]);
      end
    end
  endtask

  task automatic test_sw();
    logic        rdy [6] = '{0, 1, 0, 0, 1, 0};
    logic [18:0] exp [6] = '{E_ZERO, E_FOK, E_ZERO, E_EXSW, E_MEMSW, E_FWAIT};
    instr = 32'h0020A023;
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clk);
      mem_ready = rdy[i];
      #1;
      checks++;
      if (outs !== exp[i]) begin
        errors++;
        $display("FAIL sw cycle %0d: got %h expected %h", i, outs, exp[i]);
      end
    end
  endtask

  // zero is inverted during EXEC_TGT so a design using the live flag is caught.
  task automatic test_branch(input logic [31:0] ins, input logic z, input logic taken);
    logic        rdy [6] = '{0, 1, 0, 0, 0, 0};
    logic [18:0] exp [6];
    exp = '{E_ZERO, E_FOK, E_ZERO, E_CMP, taken ? E_TGT_T : E_TGT_N, E_FWAIT};
    instr = ins;
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clk);
      mem_ready = rdy[i];
      zero = (i == 3) ? z : ~z;
      #1;
      checks++;
      if (outs !== exp[i]) begin
        errors++;
        $display("FAIL branch %h zero=%0b cycle %0d: got %h expected %h", ins, z, i, outs, exp[i]);
      end
    end
  endtask

  task automatic test_illegal(input logic [31:0] ins);
    logic        rdy [9] = '{0, 1, 0, 1, 0, 1, 1, 1, 0};
    logic [18:0] exp [9] = '{E_ZERO, E_FOK, E_ZERO, E_TRAP1, E_TRAP1, E_TRAP1, E_TRAP1,
                             E_TRAP1, E_TRAP1};
    instr = ins;
    apply_reset();
    for (int i = 0; i < 9; i++) begin
      if (i > 0) @(negedge clk);
      mem_ready = rdy[i];
      #1;
      checks++;
      if (outs !== exp[i]) begin
        errors++;
        $display("FAIL illegal %h cycle %0d: got %h expected %h", ins, i, outs, exp[i]);
      end
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (outs !== E_ZERO) begin
      errors++;
      $display("FAIL illegal %h reset recovery: got %h expected %h", ins, outs, E_ZERO);
    end
  endtask

  task automatic test_timeout(input logic late_ready);
    logic        rdy [9];
    logic [18:0] exp [9];
    for (int i = 0; i < 9; i++) begin
      rdy[i] = 1'b0;
    end
    rdy[7] = late_ready;
    if (late_ready) begin
      exp = '{E_ZERO, E_FWAIT, E_FWAIT, E_FWAIT, E_FWAIT, E_FWAIT, E_FWAIT, E_FOK, E_ZERO};
    end else begin
      exp = '{E_ZERO, E_FWAIT, E_FWAIT, E_FWAIT, E_FWAIT, E_FWAIT, E_FWAIT, E_FWAIT, E_TRAP2};
    end
    instr = 32'h002081B3;
    apply_reset();
    for (int i = 0; i < 9; i++) begin
      if (i > 0) @(negedge clk);
      mem_ready = rdy[i];
      #1;
      checks++;
      if (outs !== exp[i]) begin
        errors++;
        $display("FAIL timeout ready7=%0b cycle %0d: got %h expected %h", late_ready, i, outs, exp[i]);
      end
    end
  endtask

  task automatic test_reset_mid_mem();
    logic        rdy [5] = '{0, 1, 0, 0, 0};
    logic [18:0] exp [5] = '{E_ZERO, E_FOK, E_ZERO, E_EXLW, E_MEMW};
    instr = 32'h0000A183;
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      mem_ready = rdy[i];
      #1;
      checks++;
      if (outs !== exp[i]) begin
        errors++;
        $display("FAIL midreset cycle %0d: got %h expected %h", i, outs, exp[i]);
      end
    end
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (outs !== E_ZERO) begin
      errors++;
      $display("FAIL midreset async clear: got %h expected %h", outs, E_ZERO);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (outs !== E_ZERO) begin
      errors++;
      $display("FAIL midreset idle: got %h expected %h", outs, E_ZERO);
    end
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    checks++;
    if (outs !== E_FWAIT) begin
      errors++;
      $display("FAIL midreset fetch: got %h expected %h", outs, E_FWAIT);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_lw();
    test_sw();
    test_branch(32'h00208463, 1'b1, 1'b1);
    test_branch(32'h00208463, 1'b0, 1'b0);
    test_branch(32'h00209463, 1'b1, 1'b0);
    test_branch(32'h00209463, 1'b0, 1'b1);
    test_illegal(32'h0000007F);
    test_illegal(32'h0020A463);
    test_timeout(1'b0);
    test_timeout(1'b1);
    test_reset_mid_mem();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
